io_bus_arbiter: RTL and testbench



---
 rtl/io_bus_arbiter_pkg.sv | 24 ++
 rtl/io_bus_interface.sv | 10 +
 rtl/io_bus_arbiter_rr.sv | 29 ++
 rtl/io_bus_arbiter.sv | 85 ++++++++
 tb/tb_io_bus_arbiter.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/io_bus_arbiter_pkg.sv
// io_bus_arbiter_pkg: shared core/request/response types, arbiter FSM states and the one-hot-to-index helper
package io_bus_arbiter_pkg;
  localparam int NUM_CORES = 4;
  localparam int IO_ARB_PERF_EVENTS = 2;
  typedef logic [3:0] core_id_t;
  typedef logic [1:0] thread_idx_t;
  typedef struct packed {
    logic        is_store;
    logic [31:0] address;
    logic [31:0] value;
    thread_idx_t thread_idx;
  } ioreq_packet_t;
  typedef struct packed {
    core_id_t    core;
    thread_idx_t thread_idx;
    logic [31:0] read_value;
  } iorsp_packet_t;
  typedef enum logic [1:0] {IO_ARB_IDLE, IO_ARB_ISSUE, IO_ARB_READ_WAIT, IO_ARB_RESPOND} io_arb_state_t;
  function automatic core_id_t oh_to_idx(input logic [15:0] oh);
    core_id_t idx = '0;
    for (int i = 0; i < 16; i++) if (oh[i]) idx |= core_id_t'(i);
    return idx;
  endfunction
endpackage

// File: rtl/io_bus_interface.sv
// io_bus_interface: non-cached peripheral I/O bus (master drives enables/address/data, slave returns read_data)
interface io_bus_interface;
  logic        write_en;
  logic        read_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  modport master(output write_en, read_en, address, write_data, input read_data);
  modport slave(input write_en, read_en, address, write_data, output read_data);
endinterface

// File: rtl/io_bus_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant; owns last_grant, which moves on update_lru
// Ports: clk, reset_n (async active-low), request (bitmap), update_lru (strobe), grant_oh (one-hot, combinational)
module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);
  localparam int IW = NUM_REQUESTERS > 1 ? $clog2(NUM_REQUESTERS) : 1;
  logic [IW-1:0] last_grant, grant_idx;
  logic [NUM_REQUESTERS-1:0] above, sel;
  // Requests above last_grant win first; otherwise wrap to the lowest request.
  always_comb begin
    above = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) above[i] = i > int'(last_grant);
    sel = |(request & above) ? request & above : request;
    grant_oh = sel & -sel;
  end
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) if (grant_oh[i]) grant_idx = IW'(i);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= IW'(NUM_REQUESTERS - 1);
    else if (update_lru && |request) last_grant <= grant_idx;
endmodule

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: round-robin sharing of the I/O bus master port between cores, one transaction in flight
// Ports: clk, reset_n (async active-low); req_valid/req_packet/req_ack per core; rsp_valid/rsp_packet
//        tagged response pulse; io_bus master port; perf_events {wait, grant} pulses.
// Build option: define IO_BUS_ARBITER_PERF_EN to generate perf_events, otherwise it is tied to 0.
module io_bus_arbiter
  import io_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQUESTERS-1:0]     req_valid,
  input  ioreq_packet_t                 req_packet [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0]     req_ack,
  output logic                          rsp_valid,
  output iorsp_packet_t                 rsp_packet,
  io_bus_interface.master               io_bus,
  output logic [IO_ARB_PERF_EVENTS-1:0] perf_events
);
  io_arb_state_t state, state_nxt;
  logic [NUM_REQUESTERS-1:0] grant, ack_d;
  ioreq_packet_t pkt, pkt_sel;
  core_id_t idx;
  logic grant_now, issue, respond;
  assign grant_now = state == IO_ARB_IDLE && |req_valid;
  assign issue = state == IO_ARB_ISSUE;
  assign respond = state == IO_ARB_RESPOND;
  rr_arbiter #(.NUM_REQUESTERS(NUM_REQUESTERS)) u_rr (
    .clk(clk),
    .reset_n(reset_n),
    .request(req_valid),
    .update_lru(grant_now),
    .grant_oh(grant)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IO_ARB_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = IO_ARB_IDLE;
    case (state)
      IO_ARB_IDLE:      state_nxt = |req_valid ? IO_ARB_ISSUE : IO_ARB_IDLE;
      IO_ARB_ISSUE:     state_nxt = pkt.is_store ? IO_ARB_RESPOND : IO_ARB_READ_WAIT;
      IO_ARB_READ_WAIT: state_nxt = IO_ARB_RESPOND;
      default:          state_nxt = IO_ARB_IDLE;
    endcase
  end
  always_comb begin
    ack_d = grant_now ? grant : '0;
    pkt_sel = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) if (grant[i]) pkt_sel = req_packet[i];
  end
  // Outputs are registered from the current state, so each bus phase appears one cycle after
  // its state; load data therefore arrives during RESPOND and is sampled there.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      req_ack <= '0;
      rsp_valid <= 1'b0;
      rsp_packet <= '0;
      io_bus.write_en <= 1'b0;
      io_bus.read_en <= 1'b0;
      io_bus.address <= '0;
      io_bus.write_data <= '0;
      pkt <= '0;
      idx <= '0;
    end else begin
      req_ack <= ack_d;
      io_bus.write_en <= issue && pkt.is_store;
      io_bus.read_en <= issue && !pkt.is_store;
      io_bus.address <= issue ? pkt.address : '0;
      io_bus.write_data <= issue ? pkt.value : '0;
      rsp_valid <= respond;
      if (grant_now) begin
        pkt <= pkt_sel;
        idx <= oh_to_idx(16'(grant));
      end
      if (respond) rsp_packet <= '{core: idx, thread_idx: pkt.thread_idx, read_value: pkt.is_store ? '0 : io_bus.read_data};
    end
`ifdef IO_BUS_ARBITER_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) perf_events <= '0;
    else perf_events <= {|(req_valid & ~ack_d), grant_now};
`else
  assign perf_events = '0;
`endif
endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb_io_bus_arbiter: randomized and directed checks of io_bus_arbiter against a transaction-level model
module tb_io_bus_arbiter;
  import io_bus_arbiter_pkg::*;
  logic clk, reset_n;
  logic [3:0] req_valid, req_ack, rv_prev;
  ioreq_packet_t req_packet [4];
  logic rsp_valid;
  iorsp_packet_t rsp_packet;
  logic [1:0] perf_events;
  logic [31:0] slave_val;
  int total = 0, bad = 0, last = 3;
  io_bus_interface io_bus();
  io_bus_arbiter #(.NUM_REQUESTERS(4)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req_valid(req_valid),
    .req_packet(req_packet),
    .req_ack(req_ack),
    .rsp_valid(rsp_valid),
    .rsp_packet(rsp_packet),
    .io_bus(io_bus),
    .perf_events(perf_events)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) begin
    rv_prev <= req_valid;
    if (io_bus.read_en) io_bus.read_data <= slave_val;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_perf(input logic [3:0] acked);
`ifdef IO_BUS_ARBITER_PERF_EN
    chk("perf", perf_events, {|(rv_prev & ~acked), |acked});
`else
    chk("perf_off", perf_events, 0);
`endif
  endtask
  function automatic ioreq_packet_t rand_pkt();
    ioreq_packet_t p;
    p.is_store = 1'($urandom_range(0, 1));
    p.address = $urandom;
    p.value = $urandom;
    p.thread_idx = 2'($urandom);
    return p;
  endfunction
  function automatic int pick(input logic [3:0] pend);
    for (int k = 1; k <= 4; k++) if (pend[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction
  task automatic txn(input logic [3:0] pend, input bit hold, input int mid, input logic [31:0] sv);
    int w;
    ioreq_packet_t p;
    req_valid = pend;
    w = pick(pend);
    tick;
    if (w < 0) begin
      chk("idle_ack", req_ack, 0);
      chk("idle_rsp", rsp_valid, 0);
      chk_perf(0);
      return;
    end
    chk("ack", req_ack, 4'b1 << w);
    chk_perf(4'b1 << w);
    last = w;
    p = req_packet[w];
    if (!hold) begin
      req_valid[w] = 1'b0;
      req_packet[w] = rand_pkt();
    end
    if (mid >= 0) req_valid = 4'(mid);
    slave_val = sv;
    tick;
    chk("issue_we", io_bus.write_en, p.is_store);
    chk("issue_re", io_bus.read_en, !p.is_store);
    chk("issue_addr", io_bus.address, p.address);
    chk("issue_wdata", io_bus.write_data, p.value);
    chk("busy_ack", req_ack, 0);
    chk("early_rsp", rsp_valid, 0);
    chk_perf(0);
    if (!p.is_store) begin
      tick;
      chk("wait_en", {io_bus.write_en, io_bus.read_en}, 0);
      chk("wait_rsp", rsp_valid, 0);
      chk("wait_ack", req_ack, 0);
      chk_perf(0);
    end
    tick;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_core", rsp_packet.core, w);
    chk("rsp_thread", rsp_packet.thread_idx, p.thread_idx);
    chk("rsp_value", rsp_packet.read_value, p.is_store ? 32'h0 : sv);
    chk("rsp_en", {io_bus.write_en, io_bus.read_en}, 0);
    chk("rsp_ack", req_ack, 0);
    chk_perf(0);
  endtask
  initial begin
    reset_n = 0;
    req_valid = 0;
    slave_val = 0;
    for (int i = 0; i < 4; i++) req_packet[i] = rand_pkt();
    tick;
    tick;
    chk("rst_ack", req_ack, 0);
    chk("rst_rsp", {rsp_valid, rsp_packet}, 0);
    chk("rst_bus", {io_bus.write_en, io_bus.read_en, io_bus.address, io_bus.write_data}, 0);
    chk("rst_perf", perf_events, 0);
    reset_n = 1;
    tick;
    req_packet[0] = '{is_store: 1'b1, address: 32'h100, value: 32'hDEADBEEF, thread_idx: 2'd0};
    txn(4'b0001, 0, -1, $urandom);
    req_packet[2] = '{is_store: 1'b0, address: 32'h20, value: 32'h0, thread_idx: 2'd1};
    txn(4'b0100, 0, -1, 32'h12345678);
    txn(4'b0001, 0, 4'b1010, $urandom);
    txn(4'b1000, 0, -1, $urandom);
    req_packet[1] = '{is_store: 1'b0, address: 32'h44, value: 32'h0, thread_idx: 2'd2};
    req_valid = 4'b0010;
    tick;
    chk("rst_load_ack", req_ack, 4'b0010);
    req_valid = 0;
    tick;
    chk("rst_load_re", io_bus.read_en, 1);
    reset_n = 0;
    #1;
    chk("rst_async_re", io_bus.read_en, 0);
    chk("rst_async_rsp", rsp_valid, 0);
    tick;
    tick;
    reset_n = 1;
    last = 3;
    repeat (3) begin
      tick;
      chk("rst_no_rsp", rsp_valid, 0);
    end
    repeat (5) txn(4'hF, 1, -1, $urandom);
    req_valid = 0;
    tick;
    repeat (150) txn(4'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : -1, $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
